pc_stack_unit: RTL and testbench

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

---
 rtl/pc_pkg.sv | 29 ++
 rtl/ret_stack.sv | 62 ++++++
 rtl/pc_stack_unit.sv | 113 +++++++++++
 tb/tb_pc_stack_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// +-------------------------------------------------------------------+
// | pc_pkg: shared defaults, state and error encodings for the PC unit |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

package pc_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DEPTH_DEF  = 8;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;
  localparam logic [1:0] ERR_ILL  = 2'b11;

  localparam logic [1:0] SRC_SEQ  = 2'b00;
  localparam logic [1:0] SRC_JMP  = 2'b01;
  localparam logic [1:0] SRC_RET  = 2'b10;
  localparam logic [1:0] SRC_RSV  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/ret_stack.sv
// +-------------------------------------------------------------------+
// | ret_stack: return-address LIFO with occupancy counter              |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

module ret_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int DW    = $clog2(DEPTH) + 1,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic [DW-1:0]     depth_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [DW-1:0]     depth_q;
  logic [DW-1:0]     depth_d;
  logic [IW-1:0]     w_wr_idx;
  logic [IW-1:0]     w_rd_idx;

  // Caller guarantees push never arrives when full and pop never when empty.
  assign w_wr_idx = IW'(depth_q);
  assign w_rd_idx = IW'(depth_q - DW'(1));

  always_comb begin
    depth_d = depth_q;
    if (push_i) begin
      depth_d = depth_q + DW'(1);
    end else if (pop_i) begin
      depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[w_wr_idx] <= push_data_i;
    end
  end

  assign top_o   = mem_q[w_rd_idx];
  assign depth_o = depth_q;

endmodule

`default_nettype wire

// File: rtl/pc_stack_unit.sv
// +-------------------------------------------------------------------+
// | pc_stack_unit: program counter with call/return stack and fault FSM|
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int DW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        pc_src,
  input  logic              stack_push,
  input  logic              stack_pop,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [DW-1:0]     depth,
  output logic              full,
  output logic              empty,
  output logic              fault,
  output logic [1:0]        err_code
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        err_q, err_d;
  logic              w_push, w_pop, w_ill;
  logic [ADDR_W-1:0] w_top, w_pc_inc;
  logic [DW-1:0]     w_depth;

  assign w_pc_inc = pc_q + ADDR_W'(1);

  ret_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ret_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (w_push),
    .pop_i       (w_pop),
    .push_data_i (w_pc_inc),
    .top_o       (w_top),
    .depth_o     (w_depth)
  );

  assign full  = (w_depth == DW'(DEPTH));
  assign empty = (w_depth == '0);

  assign w_ill = (pc_src == SRC_RSV)
               || (stack_push && stack_pop)
               || (stack_push && (pc_src != SRC_JMP))
               || (stack_pop  && (pc_src != SRC_RET))
               || ((pc_src == SRC_RET) && !stack_pop);

  // Error priority: illegal, then overflow, then underflow.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    if ((state_q == RUN) && en) begin
      if (w_ill) begin
        state_d = FAULT;
        err_d   = ERR_ILL;
      end else if (stack_push && full) begin
        state_d = FAULT;
        err_d   = ERR_OVF;
      end else if (stack_pop && empty) begin
        state_d = FAULT;
        err_d   = ERR_UNF;
      end else begin
        case (pc_src)
          SRC_SEQ: pc_d = w_pc_inc;
          SRC_JMP: begin
            pc_d   = target;
            w_push = stack_push;
          end
          SRC_RET: begin
            pc_d  = w_top;
            w_pop = 1'b1;
          end
          default: pc_d = pc_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  assign pc       = pc_q;
  assign depth    = w_depth;
  assign fault    = (state_q == FAULT);
  assign err_code = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
// +-------------------------------------------------------------------+
// | tb_pc_stack_unit: directed vector bench for pc_stack_unit          |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

module tb_pc_stack_unit;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;
  localparam int DW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [1:0]        pc_src;
  logic              stack_push;
  logic              stack_pop;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc;
  logic [DW-1:0]     depth;
  logic              full;
  logic              empty;
  logic              fault;
  logic [1:0]        err_code;

  int n_checks = 0;
  int n_fail   = 0;

  pc_stack_unit #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pc_src     (pc_src),
    .stack_push (stack_push),
    .stack_pop  (stack_pop),
    .target     (target),
    .pc         (pc),
    .depth      (depth),
    .full       (full),
    .empty      (empty),
    .fault      (fault),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              en;
    logic [1:0]        src;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] exp_pc;
    int                exp_dep;
    logic              exp_flt;
    logic [1:0]        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [1:0] s, input logic pu,
                     input logic po, input logic [ADDR_W-1:0] t, input logic [ADDR_W-1:0] p,
                     input int d, input logic f, input logic [1:0] er);
    vec_t v;
    v.rst = r; v.en = e; v.src = s; v.push = pu; v.pop = po; v.tgt = t;
    v.exp_pc = p; v.exp_dep = d; v.exp_flt = f; v.exp_err = er;
    vecs.push_back(v);
  endtask

  task automatic add_rst();
    add(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, '0, 12'h000, 0, 1'b0, 2'b00);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic chk_all(input string tag, input logic [ADDR_W-1:0] p, input int d,
                         input logic f, input logic [1:0] er);
    chk({tag, ".pc"},    32'(pc),       32'(p));
    chk({tag, ".depth"}, 32'(depth),    32'(d));
    chk({tag, ".full"},  32'(full),     32'(d == DEPTH));
    chk({tag, ".empty"}, 32'(empty),    32'(d == 0));
    chk({tag, ".fault"}, 32'(fault),    32'(f));
    chk({tag, ".err"},   32'(err_code), 32'(er));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; pc_src = 2'b00; stack_push = 1'b0; stack_pop = 1'b0; target = '0;

    // Basic sequencing, call/return, stall with illegal inputs.
    add_rst();
    for (int i = 1; i <= 5; i++) add(0, 1, 2'b00, 0, 0, '0, 12'(i), 0, 0, 2'b00);
    add(0, 1, 2'b01, 0, 0, 12'h010, 12'h010, 0, 0, 2'b00);
    add(0, 1, 2'b01, 1, 0, 12'h200, 12'h200, 1, 0, 2'b00);
    add(0, 1, 2'b00, 0, 0, '0,      12'h201, 1, 0, 2'b00);
    add(0, 1, 2'b10, 0, 1, '0,      12'h011, 0, 0, 2'b00);
    add(0, 0, 2'b11, 0, 0, '0,      12'h011, 0, 0, 2'b00);
    add(0, 0, 2'b10, 1, 1, '0,      12'h011, 0, 0, 2'b00);
    // Fill the stack, check LIFO top, then overflow.
    for (int i = 0; i < 8; i++) add(0, 1, 2'b01, 1, 0, 12'(12'h300 + 16*i), 12'(12'h300 + 16*i), i + 1, 0, 2'b00);
    add(0, 1, 2'b10, 0, 1, '0,      12'h361, 7, 0, 2'b00);
    add(0, 1, 2'b01, 1, 0, 12'h370, 12'h370, 8, 0, 2'b00);
    add(0, 1, 2'b01, 1, 0, 12'h400, 12'h370, 8, 1, 2'b01);
    for (int i = 0; i < 3; i++) add(0, 1, 2'b00, 0, 0, '0, 12'h370, 8, 1, 2'b01);
    add(0, 1, 2'b10, 0, 1, '0,      12'h370, 8, 1, 2'b01);
    add_rst();
    // Underflow and frozen fault state.
    add(0, 1, 2'b10, 0, 1, '0,      12'h000, 0, 1, 2'b10);
    for (int i = 0; i < 3; i++) add(0, 1, 2'b00, 0, 0, '0, 12'h000, 0, 1, 2'b10);
    add_rst();
    // Address wrap, including the pushed return address.
    add(0, 1, 2'b01, 0, 0, 12'hFFF, 12'hFFF, 0, 0, 2'b00);
    add(0, 1, 2'b00, 0, 0, '0,      12'h000, 0, 0, 2'b00);
    add(0, 1, 2'b01, 0, 0, 12'hFFF, 12'hFFF, 0, 0, 2'b00);
    add(0, 1, 2'b01, 1, 0, 12'h100, 12'h100, 1, 0, 2'b00);
    add(0, 1, 2'b10, 0, 1, '0,      12'h000, 0, 0, 2'b00);
    // Reset mid-call discards the return address.
    add(0, 1, 2'b01, 1, 0, 12'h123, 12'h123, 1, 0, 2'b00);
    add_rst();
    add(0, 1, 2'b10, 0, 1, '0,      12'h000, 0, 1, 2'b10);
    add_rst();
    // Illegal-control cases and priority over underflow/overflow.
    add(0, 1, 2'b01, 1, 1, 12'h050, 12'h000, 0, 1, 2'b11);
    add_rst();
    add(0, 1, 2'b11, 0, 1, '0,      12'h000, 0, 1, 2'b11);
    add_rst();
    add(0, 1, 2'b00, 0, 1, '0,      12'h000, 0, 1, 2'b11);
    add_rst();
    add(0, 1, 2'b10, 0, 0, '0,      12'h000, 0, 1, 2'b11);
    add_rst();
    for (int i = 0; i < 8; i++) add(0, 1, 2'b01, 1, 0, 12'(12'h040 + i), 12'(12'h040 + i), i + 1, 0, 2'b00);
    add(0, 1, 2'b00, 1, 0, '0,      12'h047, 8, 1, 2'b11);
    add_rst();

    for (int k = 0; k < vecs.size(); k++) begin
      string tag;
      tag = $sformatf("v%0d", k);
      if (vecs[k].rst) begin
        en = 1'b0; stack_push = 1'b0; stack_pop = 1'b0; pc_src = 2'b00;
        rst_n = 1'b0;
        #2;
        chk_all(tag, vecs[k].exp_pc, vecs[k].exp_dep, vecs[k].exp_flt, vecs[k].exp_err);
        rst_n = 1'b1;
      end else begin
        en = vecs[k].en; pc_src = vecs[k].src; stack_push = vecs[k].push;
        stack_pop = vecs[k].pop; target = vecs[k].tgt;
        @(posedge clk);
        #1;
        chk_all(tag, vecs[k].exp_pc, vecs[k].exp_dep, vecs[k].exp_flt, vecs[k].exp_err);
      end
    end

    // Held in reset across an edge, then the first edge after release takes the jump.
    rst_n = 1'b0; en = 1'b1; pc_src = 2'b01; stack_push = 1'b0; stack_pop = 1'b0; target = 12'h055;
    @(posedge clk);
    #1;
    chk_all("rst_hold", 12'h000, 0, 1'b0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rst_release", 12'h055, 0, 1'b0, 2'b00);

    // Asynchronous assertion mid-cycle, with a call pending.
    pc_src = 2'b01; stack_push = 1'b1; target = 12'h0AA;
    @(posedge clk);
    #1;
    chk_all("pre_async", 12'h0AA, 1, 1'b0, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 12'h000, 0, 1'b0, 2'b00);
    en = 1'b0; stack_push = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
